// File: rtl/muldiv_pkg.sv
// Shared constants and funct3 decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes over a shared 2*XLEN accumulator, with sign fix-up before write-back.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            wb_en,
  output logic [4:0]      wb_addr
);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_setup;
  logic [2:0]        r_f3;
  logic              r_aNeg;
  logic              r_bNeg;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN-1:0]   r_dividend;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd;
  logic [2*XLEN-1:0] r_acc;

  logic              w_aNeg;
  logic              w_bNeg;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic              w_isDiv;
  logic              w_isRem;
  logic              w_resNeg;
  logic              w_divZero;
  logic              w_overflow;
  logic [XLEN-1:0]   w_fastResult;
  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quoFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_finResult;

  assign w_aNeg = a_signed(funct3) && op_a[XLEN-1];
  assign w_bNeg = b_signed(funct3) && op_b[XLEN-1];
  assign w_absA = w_aNeg ? -op_a : op_a;
  assign w_absB = w_bNeg ? -op_b : op_b;

  assign w_isDiv  = is_div(r_f3);
  assign w_isRem  = w_isDiv && r_f3[1];
  assign w_resNeg = w_isRem ? r_aNeg : (r_aNeg ^ r_bNeg);

  // While dividing, the accumulator low half still holds |op_a| during the setup cycle.
  assign w_divZero  = w_isDiv && (r_opnd == '0);
  assign w_overflow = w_isDiv && b_signed(r_f3) && r_aNeg && r_bNeg &&
                      (r_acc[XLEN-1:0] == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (r_opnd == XLEN'(1));
  assign w_fastResult = w_isRem ? (w_divZero ? r_dividend : '0)
                                : (w_divZero ? '1 : {1'b1, {(XLEN-1){1'b0}}});

  assign w_mulSum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_trial  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff   = w_trial - {1'b0, r_opnd};
  // A set borrow bit means the trial remainder was smaller than the divisor.
  assign w_step = !w_isDiv ? {w_mulSum, r_acc[XLEN-1:1]} :
                  w_diff[XLEN] ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                               : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  assign w_prodFix = w_resNeg ? -r_acc : r_acc;
  assign w_quoFix  = w_resNeg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_remFix  = w_resNeg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_finResult = w_prodFix[2*XLEN-1:XLEN];
    if (w_isDiv) begin
      w_finResult = w_isRem ? w_remFix : w_quoFix;
    end else if (r_f3 == F3_MUL) begin
      w_finResult = w_prodFix[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_setup    <= 1'b0;
      r_f3       <= '0;
      r_aNeg     <= 1'b0;
      r_bNeg     <= 1'b0;
      r_opnd     <= '0;
      r_dividend <= '0;
      r_result   <= '0;
      r_rd       <= '0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        S_CALC: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else if (r_setup) begin
            // First busy cycle only decides the divide fast path; iterations start next edge.
            r_setup <= 1'b0;
            if (w_divZero || w_overflow) begin
              r_result <= w_fastResult;
              r_state  <= S_OUT;
            end
          end else begin
            r_acc <= w_step;
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state <= S_FIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_FIN: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_finResult;
            r_state  <= S_OUT;
          end
        end
        default: begin
          if (start) begin
            r_state    <= S_CALC;
            r_setup    <= 1'b1;
            r_cnt      <= '0;
            r_f3       <= funct3;
            r_rd       <= rd_addr;
            r_aNeg     <= w_aNeg;
            r_bNeg     <= w_bNeg;
            r_dividend <= op_a;
            r_opnd     <= is_div(funct3) ? w_absB : w_absA;
            r_acc      <= {{XLEN{1'b0}}, (is_div(funct3) ? w_absA : w_absB)};
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = (r_state == S_CALC) || (r_state == S_FIN);
  assign done    = (r_state == S_OUT);
  assign result  = r_result;
  assign wb_addr = r_rd;
  assign wb_en   = done && (r_rd != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_addr;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        wb_en;
  logic [4:0]  wb_addr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] lastExp = '0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t dirVecs[13];

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_addr(rd_addr),
    .busy   (busy),
    .done   (done),
    .result (result),
    .wb_en  (wb_en),
    .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  // Reference model: plain signed/unsigned arithmetic with the RV32M corner-case rules.
  function automatic logic [31:0] modelResult(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (f3)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'b001: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
      3'b010: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFFFFFF :
                  (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: r = (b == 0) ? a :
                  (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int modelLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 34;
  endfunction

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    funct3  = f3;
    op_a    = a;
    op_b    = b;
    rd_addr = rd;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until done is seen, 0 on timeout.
  task automatic waitDone(output int k);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks += 5;
    if (busy !== 1'b0)    begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (wb_en !== 1'b0)   begin failures++; $display("[TB] FAIL reset_wb_en: got %b expected 0", wb_en); end
    if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    if (wb_addr !== 5'h0) begin failures++; $display("[TB] FAIL reset_wb_addr: got %h expected 0", wb_addr); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic runOne(input string tag, input vec_t v);
    int k;
    applyStimulus(v.f3, v.a, v.b, v.rd);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL %s_busy_after_accept: got %b expected 1", tag, busy); end
    waitDone(k);
    checks += 5;
    if (k != v.lat) begin failures++; $display("[TB] FAIL %s_latency: got %0d expected %0d", tag, k, v.lat); end
    if (result !== v.exp) begin failures++; $display("[TB] FAIL %s_result: got %h expected %h", tag, result, v.exp); end
    if (wb_en !== (v.rd != 0)) begin failures++; $display("[TB] FAIL %s_wb_en: got %b expected %b", tag, wb_en, v.rd != 0); end
    if (wb_addr !== v.rd) begin failures++; $display("[TB] FAIL %s_wb_addr: got %0d expected %0d", tag, wb_addr, v.rd); end
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL %s_busy_at_done: got %b expected 0", tag, busy); end
    lastExp = v.exp;
    @(posedge clk);
    #1;
    checks += 2;
    if (done !== 1'b0 || wb_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_single_pulse: got done=%b wb_en=%b expected 0 0", tag, done, wb_en);
    end
    if (result !== v.exp) begin failures++; $display("[TB] FAIL %s_result_held: got %h expected %h", tag, result, v.exp); end
  endtask

  task automatic test_directed;
    dirVecs = '{
      '{3'b000, 32'd7,         32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34},
      '{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 34},
      '{3'b001, 32'h80000000,  32'h80000000, 5'd4,  32'h40000000, 34},
      '{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 34},
      '{3'b100, 32'hFFFFFFF9,  32'd2,        5'd7,  32'hFFFFFFFD, 34},
      '{3'b110, 32'hFFFFFFF9,  32'd2,        5'd8,  32'hFFFFFFFF, 34},
      '{3'b101, 32'd100,       32'd7,        5'd9,  32'd14,       34},
      '{3'b111, 32'd100,       32'd7,        5'd10, 32'd2,        34},
      '{3'b101, 32'd5,         32'd0,        5'd11, 32'hFFFFFFFF, 1},
      '{3'b111, 32'd5,         32'd0,        5'd12, 32'd5,        1},
      '{3'b100, 32'h80000000,  32'hFFFFFFFF, 5'd13, 32'h80000000, 1},
      '{3'b110, 32'h80000000,  32'hFFFFFFFF, 5'd14, 32'h0,        1},
      '{3'b000, 32'd3,         32'd5,        5'd0,  32'd15,       34}
    };
    for (int i = 0; i < 13; i++) begin
      runOne($sformatf("dir%0d", i), dirVecs[i]);
    end
  endtask

  task automatic test_random;
    vec_t v;
    int sel;
    for (int i = 0; i < 24; i++) begin
      v.f3 = 3'($urandom_range(0, 7));
      v.a  = $urandom;
      sel  = $urandom_range(0, 5);
      case (sel)
        0: v.b = 32'h0;
        1: begin v.a = 32'h80000000; v.b = 32'hFFFFFFFF; end
        2: v.b = 32'($urandom_range(1, 15));
        3: v.b = -32'($urandom_range(1, 15));
        default: v.b = $urandom;
      endcase
      v.rd  = 5'($urandom_range(0, 31));
      v.exp = modelResult(v.f3, v.a, v.b);
      v.lat = modelLatency(v.f3, v.a, v.b);
      runOne($sformatf("rnd%0d_f%0d", i, v.f3), v);
    end
  endtask

  task automatic test_kill;
    int seen = 0;
    applyStimulus(3'b000, $urandom, $urandom, 5'd17);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL kill_busy: got %b expected 0", busy); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    checks += 2;
    if (seen != 0) begin failures++; $display("[TB] FAIL kill_no_done: got %0d done pulses expected 0", seen); end
    if (result !== lastExp) begin failures++; $display("[TB] FAIL kill_result_kept: got %h expected %h", result, lastExp); end
  endtask

  task automatic test_start_while_busy;
    int seen = 0;
    logic [31:0] got = '0;
    logic [4:0]  gotRd = '0;
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_addr = 5'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin seen++; got = result; gotRd = wb_addr; end
    end
    checks += 3;
    if (seen != 1) begin failures++; $display("[TB] FAIL busy_start_single_done: got %0d expected 1", seen); end
    if (got !== 32'd14) begin failures++; $display("[TB] FAIL busy_start_result: got %h expected %h", got, 32'd14); end
    if (gotRd !== 5'd9) begin failures++; $display("[TB] FAIL busy_start_wb_addr: got %0d expected 9", gotRd); end
    lastExp = 32'd14;
  endtask

  task automatic test_back_to_back;
    int k;
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
    waitDone(k);
    checks++;
    if (result !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL b2b_first_result: got %h expected fffffffe", result); end
    funct3 = 3'b100; op_a = 32'hFFFFFFF9; op_b = 32'd2; rd_addr = 5'd22; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    waitDone(k);
    checks += 3;
    if (k != 34) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 34", k); end
    if (result !== 32'hFFFFFFFD) begin failures++; $display("[TB] FAIL b2b_second_result: got %h expected fffffffd", result); end
    if (wb_addr !== 5'd22) begin failures++; $display("[TB] FAIL b2b_wb_addr: got %0d expected 22", wb_addr); end
    lastExp = 32'hFFFFFFFD;
  endtask

  task automatic test_reset_mid;
    applyStimulus(3'b110, $urandom, 32'd13, 5'd25);
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0)    begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin failures++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
    if (wb_en !== 1'b0)   begin failures++; $display("[TB] FAIL midreset_wb_en: got %b expected 0", wb_en); end
    if (result !== 32'h0) begin failures++; $display("[TB] FAIL midreset_result: got %h expected 0", result); end
    if (wb_addr !== 5'h0) begin failures++; $display("[TB] FAIL midreset_wb_addr: got %h expected 0", wb_addr); end
    @(negedge clk);
    reset = 1'b1;
    lastExp = '0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_addr = '0;
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
